add_arbiter: RTL and testbench
==============================

Name: add_arbiter

Overview:
- Shares one WIDTH-bit adder (sum, carry, signed overflow) among N_REQ requesters, e.g. PC+4, branch-target and address-calc users.
- Round-robin arbitration with a req/ack handshake on the request side.
- One-entry registered result slot with valid/ready backpressure.
- Sits between pipeline-stage requesters and the adder; results return tagged with the requester index.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and result width.
- ID_W, 2, width of requester index; must satisfy 2^ID_W >= N_REQ.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  N_REQ  per-requester request, bit i = requester i.
- op_a  in  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- op_b  in  N_REQ*WIDTH  operand B, same packing.
- ack  out  N_REQ  one-hot accept pulse, combinational, bit i = requester i.
- res_valid  out  1  result slot holds a result.
- res_ready  in  1  consumer accepts the result this cycle.
- res_data  out  WIDTH  (a+b) mod 2^WIDTH.
- res_carry  out  1  unsigned carry-out of the add.
- res_ovf  out  1  signed overflow: operands same sign, sum sign differs.
- res_id  out  ID_W  index of the requester that owns the result.
- busy  out  1  res_valid and not res_ready (slot blocked).

Behaviour:
- Reset, sampled on clk edge with rst=1:
  - res_valid=0, res_data=0, res_carry=0, res_ovf=0, res_id=0.
  - Round-robin pointer ptr=0.
  - ack forced to all-zero while rst=1.
- Reset mid-operation discards any held result; no ack is issued in that cycle.
- Slot free: slot_free = !res_valid || res_ready.
- Arbitration, combinational, every cycle:
  - When slot_free and any req bit is set, the winner is the first set req bit scanning from ptr upward, wrapping mod N_REQ.
  - ack is one-hot on the winner; otherwise ack=0.
  - At most one ack per cycle.
- On a clk edge with a winner w:
  - res_data <= a_w + b_w; res_carry and res_ovf are computed from the same add.
  - res_id <= w; res_valid <= 1.
  - ptr <= (w+1) mod N_REQ.
- On a clk edge with no winner and res_ready=1: res_valid <= 0. Data fields hold their last value.
- res_valid=1 and res_ready=0: all res_* outputs hold stable, no ack, ptr unchanged.
- Simultaneous drain and new grant (res_valid=1, res_ready=1, req pending):
  - Grant proceeds in the same cycle.
  - res_valid stays 1 and carries the new result: back-to-back throughput of one result per cycle.
- Latency: ack in cycle t, result visible with res_valid=1 from cycle t+1.
- Requester rules:
  - Hold req high with stable operands until ack is seen.
  - Deassert req in the cycle after ack unless issuing a new request.
  - Dropping req before ack is legal; no result is produced for it.
- Operands are sampled only in the ack cycle.
- Fairness: a continuously requesting requester is granted within N_REQ grants.
- Arithmetic wraps mod 2^WIDTH; there are no exceptions and no saturation.
- Internal control state is EMPTY (res_valid=0) or FULL (res_valid=1):
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY on res_ready with no grant.
  - FULL -> FULL on grant-with-drain or on stall.

Test Plan:
- Reset then single request: rst for 2 cycles; req=0001, op_a[0]=0x00400000, op_b[0]=4, res_ready=1.
  - ack=0001 in the same cycle.
  - Next cycle: res_valid=1, res_data=0x00400004, res_id=0, carry=0, ovf=0.
- Carry and overflow: req[2] with a=0xFFFFFFFF, b=1 -> res_data=0, carry=1, ovf=0. Then a=0x7FFFFFFF, b=1 -> res_data=0x80000000, carry=0, ovf=1.
- Round robin: req=1111 held with res_ready=1 -> ack sequence 0001, 0010, 0100, 1000, 0001; res_id 0,1,2,3,0 on consecutive cycles.
- Backpressure: result pending, res_ready=0 for 3 cycles while req=0010.
  - ack=0, busy=1, res_* stable for all 3 cycles.
  - Raise res_ready: ack=0010 that cycle; the next cycle holds the new result.
- Withdraw request: req[3] raised during a stall, dropped before the slot frees -> no ack[3], no result with res_id=3.
- Reset mid-operation: res_valid=1 with res_ready=0, assert rst one cycle while req=0100.
  - ack=0 during rst.
  - After reset: res_valid=0, ptr=0.
  - Next grant goes to the lowest set req bit.

Source files
------------

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter sharing one WIDTH-bit adder among N_REQ requesters.
// Latency: ack is combinational in cycle t; the tagged result is valid from cycle t+1.
// Backpressure: a full result slot with res_ready=0 blocks all grants (busy=1).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req, op_a, op_b     per-requester request and packed operands ([i*WIDTH +: WIDTH])
//   ack                 one-hot combinational accept, bit i = requester i
//   res_valid/res_ready result slot handshake
//   res_data/carry/ovf  sum mod 2^WIDTH, unsigned carry-out, signed overflow
//   res_id              index of the requester owning the result
//   busy                res_valid && !res_ready
module add_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   op_a,
  input  logic [N_REQ*WIDTH-1:0]   op_b,
  output logic [N_REQ-1:0]         ack,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic                     res_carry,
  output logic                     res_ovf,
  output logic [ID_W-1:0]          res_id,
  output logic                     busy
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic              res_carry_q, res_carry_d;
  logic              res_ovf_q, res_ovf_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;

  logic                 slot_free;
  logic                 grant;
  logic [2*N_REQ-1:0]   req_dbl;
  logic [2*N_REQ-1:0]   req_rot;
  logic                 found;
  int                   win_off;
  int                   win_int;
  int                   nxt_int;
  logic [WIDTH-1:0]     a_sel;
  logic [WIDTH-1:0]     b_sel;
  logic [WIDTH-1:0]     sum;
  logic                 carry;
  logic                 ovf;

  assign res_valid = (state_q == ST_FULL);
  assign slot_free = !res_valid || res_ready;
  assign busy      = res_valid && !res_ready;

  // Rotate the request vector so that bit 0 is the requester at ptr; the first
  // set bit of the rotated vector is then the round-robin winner offset.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl >> ptr_q;
    found   = 1'b0;
    win_off = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found   = 1'b1;
        win_off = k;
      end
    end
    win_int = int'(ptr_q) + win_off;
    if (win_int >= N_REQ) begin
      win_int = win_int - N_REQ;
    end
  end

  // Reset suppresses acceptance so nothing is granted into a discarded slot.
  assign grant = found && slot_free && !rst;

  always_comb begin
    ack   = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_int == i) begin
        ack[i] = grant;
        a_sel  = op_a[i*WIDTH +: WIDTH];
        b_sel  = op_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Single shared adder; overflow when both operands share a sign the sum lacks.
  always_comb begin
    {carry, sum} = {1'b0, a_sel} + {1'b0, b_sel};
    ovf          = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) && (sum[WIDTH-1] != a_sel[WIDTH-1]);
  end

  always_comb begin
    nxt_int = win_int + 1;
    if (nxt_int >= N_REQ) begin
      nxt_int = 0;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_ovf_d   = res_ovf_q;
    res_id_d    = res_id_q;

    if (grant) begin
      res_data_d  = sum;
      res_carry_d = carry;
      res_ovf_d   = ovf;
      res_id_d    = ID_W'(win_int);
      ptr_d       = ID_W'(nxt_int);
    end

    case (state_q)
      ST_EMPTY: begin
        if (grant) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        // A grant during drain refills the slot in the same cycle.
        if (!grant && res_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      ptr_q       <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_ovf_q   <= res_ovf_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_ovf   = res_ovf_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter (N_REQ=4, WIDTH=32, ID_W=2).
// Inputs change on the falling edge; outputs are sampled 1ns after it.
// A behavioural model tracks the result slot and round-robin pointer.
module tb_add_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic [N-1:0]   ack;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic           res_carry;
  logic           res_ovf;
  logic [1:0]     res_id;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_carry;
  logic         m_ovf;
  logic [1:0]   m_id;
  int           m_ptr;

  add_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .ack(ack),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_ovf(res_ovf), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // First requesting index scanning upward from the pointer, or -1.
  function automatic int model_winner();
    if (rst) return -1;
    if (m_valid && !res_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ack();
    int w;
    logic [N-1:0] one;
    w = model_winner();
    one = 1;
    if (w < 0) return '0;
    return one << w;
  endfunction

  function automatic logic [W+W+5:0] model_res();
    return {m_valid, m_data, m_carry, m_ovf, m_id, (m_valid && !res_ready), m_data};
  endfunction

  function automatic logic [W+W+5:0] dut_res();
    return {res_valid, res_data, res_carry, res_ovf, res_id, busy, res_data};
  endfunction

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_ops(i, $urandom, $urandom);
  endtask

  // Advance one clock and update the model; returns just after the falling edge.
  task automatic tick();
    int           w;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [63:0]  s;
    longint       ss;
    w = model_winner();
    a = '0;
    b = '0;
    if (w >= 0) begin
      a = op_a[w*W +: W];
      b = op_b[w*W +: W];
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_carry = 1'b0; m_ovf = 1'b0; m_id = '0; m_ptr = 0;
    end else if (w >= 0) begin
      s       = {32'b0, a} + {32'b0, b};
      m_data  = s[W-1:0];
      m_carry = (s > 64'h0000_0000_FFFF_FFFF);
      ss      = longint'($signed(a)) + longint'($signed(b));
      m_ovf   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      m_id    = 2'(w);
      m_valid = 1'b1;
      m_ptr   = (w + 1) % N;
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0001; res_ready = 1'b1; rand_ops();
    #1;
    n_vec++;
    if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack got=%b want=0000", ack); end
    tick();
    tick();
    n_vec++;
    if ({res_valid, res_data, res_carry, res_ovf, res_id} !== {1'b0, 32'h0, 1'b0, 1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_state got v=%b d=%h c=%b o=%b id=%0d want all zero",
               res_valid, res_data, res_carry, res_ovf, res_id);
    end
    rst = 1'b0; req = '0;
    #1;
  endtask

  task automatic test_single();
    req = 4'b0001; res_ready = 1'b1;
    set_ops(0, 32'h0040_0000, 32'h0000_0004);
    #1;
    n_vec++;
    if (ack !== 4'b0001) begin n_err++; $display("FAIL single_ack got=%b want=0001", ack); end
    tick();
    req = '0;
    #1;
    n_vec++;
    if ({res_valid, res_data, res_carry, res_ovf, res_id} !== {1'b1, 32'h0040_0004, 1'b0, 1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL single_res got v=%b d=%h c=%b o=%b id=%0d want v=1 d=00400004 c=0 o=0 id=0",
               res_valid, res_data, res_carry, res_ovf, res_id);
    end
  endtask

  task automatic test_carry_ovf();
    logic [W-1:0] av [2];
    logic [W+3:0] want [2];
    av[0] = 32'hFFFF_FFFF; av[1] = 32'h7FFF_FFFF;
    want[0] = {32'h0000_0000, 1'b1, 1'b0, 2'd2};
    want[1] = {32'h8000_0000, 1'b0, 1'b1, 2'd2};
    for (int t = 0; t < 2; t++) begin
      req = 4'b0100; res_ready = 1'b1;
      set_ops(2, av[t], 32'h1);
      #1;
      n_vec++;
      if (ack !== 4'b0100) begin n_err++; $display("FAIL carry_ack[%0d] got=%b want=0100", t, ack); end
      tick();
      req = '0;
      #1;
      n_vec++;
      if ({res_data, res_carry, res_ovf, res_id} !== want[t]) begin
        n_err++;
        $display("FAIL carry_res[%0d] got=%h want=%h", t, {res_data, res_carry, res_ovf, res_id}, want[t]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] rr_exp [5];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0; res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req = 4'b1111; rand_ops();
      #1;
      n_vec++;
      if (ack !== rr_exp[k]) begin n_err++; $display("FAIL rr_ack[%0d] got=%b want=%b", k, ack, rr_exp[k]); end
      tick();
      n_vec++;
      if (res_id !== 2'(k % N) || dut_res() !== model_res()) begin
        n_err++;
        $display("FAIL rr_res[%0d] got id=%0d d=%h want id=%0d d=%h", k, res_id, res_data, k % N, m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W+3:0] snap;
    snap = {res_data, res_carry, res_ovf, res_id};
    res_ready = 1'b0; req = 4'b0010; rand_ops();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (ack !== 4'b0000 || busy !== 1'b1 || res_valid !== 1'b1 ||
          {res_data, res_carry, res_ovf, res_id} !== snap) begin
        n_err++;
        $display("FAIL stall[%0d] got ack=%b busy=%b v=%b res=%h want ack=0000 busy=1 v=1 res=%h",
                 k, ack, busy, res_valid, {res_data, res_carry, res_ovf, res_id}, snap);
      end
      tick();
    end
    res_ready = 1'b1;
    #1;
    n_vec++;
    if (ack !== 4'b0010) begin n_err++; $display("FAIL stall_release_ack got=%b want=0010", ack); end
    tick();
    req = '0;
    #1;
    n_vec++;
    if (res_id !== 2'd1 || res_valid !== 1'b1 || dut_res() !== model_res()) begin
      n_err++;
      $display("FAIL stall_release_res got id=%0d v=%b d=%h want id=1 v=1 d=%h", res_id, res_valid, res_data, m_data);
    end
  endtask

  task automatic test_withdraw();
    res_ready = 1'b0; req = 4'b1000; rand_ops();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) req = '0;
      if (k == 3) res_ready = 1'b1;
      #1;
      n_vec++;
      if (ack[3] !== 1'b0) begin n_err++; $display("FAIL withdraw_ack[%0d] got=%b want ack[3]=0", k, ack); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if ((res_valid && res_id == 2'd3) || dut_res() !== model_res()) begin
        n_err++;
        $display("FAIL withdraw_res[%0d] got v=%b id=%0d want v=%b id=%0d", k, res_valid, res_id, m_valid, m_id);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    req = 4'b0001; res_ready = 1'b1; rand_ops();
    tick();
    res_ready = 1'b0; req = 4'b0100; rst = 1'b1;
    #1;
    n_vec++;
    if (ack !== 4'b0000) begin n_err++; $display("FAIL midrst_ack got=%b want=0000", ack); end
    tick();
    rst = 1'b0; req = '0;
    #1;
    n_vec++;
    if (res_valid !== 1'b0 || dut_res() !== model_res()) begin
      n_err++;
      $display("FAIL midrst_state got v=%b d=%h id=%0d want v=0 d=0 id=0", res_valid, res_data, res_id);
    end
    req = 4'b0110; res_ready = 1'b1;
    #1;
    n_vec++;
    if (ack !== 4'b0010) begin n_err++; $display("FAIL midrst_grant got=%b want=0010", ack); end
    tick();
    req = '0;
    #1;
    n_vec++;
    if (res_id !== 2'd1 || dut_res() !== model_res()) begin
      n_err++;
      $display("FAIL midrst_res got id=%0d d=%h want id=1 d=%h", res_id, res_data, m_data);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req = 4'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      rand_ops();
      #1;
      n_vec++;
      if (ack !== model_ack()) begin
        n_err++;
        $display("FAIL rand_ack[%0d] got=%b want=%b", k, ack, model_ack());
      end
      n_vec++;
      if (dut_res() !== model_res()) begin
        n_err++;
        $display("FAIL rand_res[%0d] got v=%b d=%h c=%b o=%b id=%0d busy=%b want v=%b d=%h c=%b o=%b id=%0d",
                 k, res_valid, res_data, res_carry, res_ovf, res_id, busy,
                 m_valid, m_data, m_carry, m_ovf, m_id);
      end
      tick();
    end
    rst = 1'b0; req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; res_ready = 1'b1; op_a = '0; op_b = '0;
    m_valid = 1'b0; m_data = '0; m_carry = 1'b0; m_ovf = 1'b0; m_id = '0; m_ptr = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_carry_ovf();
    test_round_robin();
    test_backpressure();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
